pe_loader: RTL and testbench

PE_LOADER -- requirements
Module: pe_loader

---
 rtl/pe_loader_pkg.sv | 16 +
 rtl/pe_loader_burst_buf.sv | 29 ++
 rtl/pe_loader.sv | 142 ++++++++++++++
 tb/tb_pe_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_loader_pkg.sv
// Shared parameters and state encoding for the PE loader.
package pe_loader_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned REG_NUM    = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StInst  = 3'd1,
    StFill  = 3'd2,
    StBurst = 3'd3,
    StDone  = 3'd4
  } pe_state_e;

endpackage

// File: rtl/pe_loader_burst_buf.sv
// Sample store: simple dual-port RAM with a registered read port.
module burst_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pe_loader.sv
// Loads a job's instructions into a PE, buffers one data burst, then streams it out gap-free.
module pe_loader #(
  parameter int unsigned DATA_WIDTH = pe_loader_pkg::DATA_WIDTH,
  parameter int unsigned INST_WIDTH = pe_loader_pkg::INST_WIDTH,
  parameter int unsigned BURST_LEN  = pe_loader_pkg::REG_NUM * 2,
  parameter int unsigned INST_MAX   = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic [$clog2(INST_MAX+1)-1:0]    i_inst_cnt,
  input  logic                             i_s_inst_v,
  output logic                             o_s_inst_ready,
  input  logic [INST_WIDTH-1:0]            i_s_inst,
  input  logic                             i_s_data_v,
  output logic                             o_s_data_ready,
  input  logic [DATA_WIDTH*2-1:0]          i_s_data,
  output logic                             o_inst_in_v,
  output logic [INST_WIDTH-1:0]            o_inst_in,
  output logic                             o_din_v,
  output logic [DATA_WIDTH*2-1:0]          o_din_pe,
  output logic                             o_busy,
  output logic                             o_done
);

  import pe_loader_pkg::*;

  localparam int unsigned CntW  = $clog2(INST_MAX + 1);
  localparam int unsigned AddrW = $clog2(BURST_LEN);

  pe_state_e              r_state, w_state_nxt;
  logic [CntW-1:0]        r_inst_tgt, r_icnt, w_cnt_clamped;
  logic [AddrW-1:0]       r_wcnt, r_rcnt;
  logic                   r_rd_done;
  logic                   r_inst_v, r_din_v;
  logic [INST_WIDTH-1:0]  r_inst;
  logic                   w_inst_ready, w_data_ready, w_inst_hs, w_data_hs, w_rd_en;
  logic [DATA_WIDTH*2-1:0] w_rd_data;

  assign w_cnt_clamped = (i_inst_cnt > CntW'(INST_MAX)) ? CntW'(INST_MAX) : i_inst_cnt;
  assign w_inst_hs     = w_inst_ready & i_s_inst_v;
  assign w_data_hs     = w_data_ready & i_s_data_v;

  always_comb begin
    w_state_nxt  = r_state;
    w_inst_ready = 1'b0;
    w_data_ready = 1'b0;
    w_rd_en      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = (w_cnt_clamped != '0) ? StInst : StFill;
        end
      end
      StInst: begin
        w_inst_ready = 1'b1;
        if (i_s_inst_v && (r_icnt == r_inst_tgt - CntW'(1))) begin
          w_state_nxt = StFill;
        end
      end
      StFill: begin
        w_data_ready = 1'b1;
        if (i_s_data_v && (r_wcnt == AddrW'(BURST_LEN - 1))) begin
          w_state_nxt = StBurst;
        end
      end
      StBurst: begin
        // Reads issue until the last address; the final word leaves one cycle later.
        w_rd_en = ~r_rd_done;
        if (r_rd_done) begin
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_inst_tgt <= '0;
      r_icnt     <= '0;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_rd_done  <= 1'b0;
      r_inst_v   <= 1'b0;
      r_inst     <= '0;
      r_din_v    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_inst_v <= w_inst_hs;
      r_inst   <= w_inst_hs ? i_s_inst : '0;
      r_din_v  <= w_rd_en;
      if (r_state == StIdle && i_start) begin
        r_inst_tgt <= w_cnt_clamped;
      end
      if (w_inst_hs) begin
        r_icnt <= r_icnt + CntW'(1);
      end
      if (w_data_hs) begin
        r_wcnt <= (r_wcnt == AddrW'(BURST_LEN - 1)) ? '0 : r_wcnt + AddrW'(1);
      end
      if (w_rd_en) begin
        r_rcnt <= r_rcnt + AddrW'(1);
        if (r_rcnt == AddrW'(BURST_LEN - 1)) begin
          r_rd_done <= 1'b1;
        end
      end
      if (w_state_nxt == StIdle) begin
        r_icnt    <= '0;
        r_wcnt    <= '0;
        r_rcnt    <= '0;
        r_rd_done <= 1'b0;
      end
    end
  end

  burst_buf #(
    .DEPTH (BURST_LEN),
    .WIDTH (DATA_WIDTH * 2)
  ) u_burst_buf (
    .i_clk   (i_clk),
    .i_we    (w_data_hs),
    .i_waddr (r_wcnt),
    .i_wdata (i_s_data),
    .i_re    (w_rd_en),
    .i_raddr (r_rcnt),
    .o_rdata (w_rd_data)
  );

  // Buffer read data is unreset; gate it so the output is clean when idle or in reset.
  assign o_din_pe       = r_din_v ? w_rd_data : '0;
  assign o_din_v        = r_din_v;
  assign o_inst_in_v    = r_inst_v;
  assign o_inst_in      = r_inst;
  assign o_s_inst_ready = w_inst_ready;
  assign o_s_data_ready = w_data_ready;
  assign o_busy         = (r_state != StIdle);
  assign o_done         = (r_state == StDone);

endmodule

// File: tb/tb_pe_loader.sv
// Randomized self-checking bench for pe_loader against a queue-based job model.
module tb_pe_loader;

  localparam int DW   = 64;
  localparam int IW   = 32;
  localparam int BL   = 64;
  localparam int IMAX = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    inst_cnt = '0;
  logic          s_inst_v = 1'b0;
  logic          s_inst_ready;
  logic [IW-1:0] s_inst = '0;
  logic          s_data_v = 1'b0;
  logic          s_data_ready;
  logic [DW-1:0] s_data = '0;
  logic          inst_in_v;
  logic [IW-1:0] inst_in;
  logic          din_v;
  logic [DW-1:0] din_pe;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [IW-1:0] q_inst[$];
  int            q_inst_c[$];
  logic [DW-1:0] q_din[$];
  int            q_din_c[$];
  int            q_done_c[$];
  int            n_irdy = 0;
  int            n_drdy = 0;

  pe_loader dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_inst_cnt     (inst_cnt),
    .i_s_inst_v     (s_inst_v),
    .o_s_inst_ready (s_inst_ready),
    .i_s_inst       (s_inst),
    .i_s_data_v     (s_data_v),
    .o_s_data_ready (s_data_ready),
    .i_s_data       (s_data),
    .o_inst_in_v    (inst_in_v),
    .o_inst_in      (inst_in),
    .o_din_v        (din_v),
    .o_din_pe       (din_pe),
    .o_busy         (busy),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output observer: logs every output event with its cycle number.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inst_in_v) begin
        q_inst.push_back(inst_in);
        q_inst_c.push_back(cyc);
      end else begin
        checks++;
        if (inst_in !== '0) begin
          errors++;
          $display("FAIL inst_in_idle cyc %0d got %h exp 0", cyc, inst_in);
        end
      end
      if (din_v) begin
        q_din.push_back(din_pe);
        q_din_c.push_back(cyc);
      end else begin
        checks++;
        if (din_pe !== '0) begin
          errors++;
          $display("FAIL din_pe_idle cyc %0d got %h exp 0", cyc, din_pe);
        end
      end
      if (done) q_done_c.push_back(cyc);
      if (s_inst_ready) n_irdy++;
      if (s_data_ready) n_drdy++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // mode 0: host always valid; 1: data valid toggles during FILL; 2: random gaps.
  task automatic run_job(input string name, input int n_req, input int mode,
                         input int inst_base, input int data_base, input bit inject);
    logic [IW-1:0] insts[$];
    logic [DW-1:0] datas[$];
    int exp_n, start_c, ip, dp, budget, k;
    bit tog, ihs, dhs;
    for (int i = 0; i < n_req; i++)
      insts.push_back(inst_base >= 0 ? IW'(inst_base + i) : IW'($urandom()));
    for (int i = 0; i < BL; i++)
      datas.push_back(data_base >= 0 ? DW'(data_base + i) : {$urandom(), $urandom()});
    exp_n = (n_req > IMAX) ? IMAX : n_req;
    q_inst.delete(); q_inst_c.delete(); q_din.delete(); q_din_c.delete(); q_done_c.delete();
    n_irdy = 0; n_drdy = 0;
    ip = 0; dp = 0; tog = 1'b0;

    @(negedge clk);
    start = 1'b1; inst_cnt = n_req[4:0]; start_c = cyc;
    s_inst_v = 1'b0; s_data_v = 1'b0;
    @(negedge clk);
    start = 1'b0;
    budget = 2000;
    while (dp < BL && budget > 0) begin
      budget--;
      s_inst_v = (ip < insts.size()) && (mode != 2 || $urandom_range(0, 1) == 1);
      s_inst   = (ip < insts.size()) ? insts[ip] : '0;
      case (mode)
        0: s_data_v = 1'b1;
        1: begin
          if (s_data_ready) begin
            s_data_v = tog;
            tog = ~tog;
          end else begin
            s_data_v = 1'b1;
          end
        end
        default: s_data_v = ($urandom_range(0, 1) == 1);
      endcase
      s_data = datas[dp];
      ihs = s_inst_v && s_inst_ready;
      dhs = s_data_v && s_data_ready;
      @(negedge clk);
      if (ihs) ip++;
      if (dhs) dp++;
    end
    s_inst_v = 1'b0; s_data_v = 1'b0;
    checks++;
    if (dp != BL) begin
      errors++;
      $display("FAIL %s fill_timeout got %0d words exp %0d", name, dp, BL);
    end

    k = 0;
    while (q_done_c.size() == 0 && k < 300) begin
      if (inject && k == 5) begin
        start = 1'b1; inst_cnt = 5'd2; s_inst_v = 1'b1; s_data_v = 1'b1;
      end
      if (inject && k == 6) start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    s_inst_v = 1'b0; s_data_v = 1'b0;

    checks++;
    if (q_inst.size() != exp_n) begin
      errors++;
      $display("FAIL %s inst_count got %0d exp %0d", name, q_inst.size(), exp_n);
    end
    for (int i = 0; i < exp_n && i < q_inst.size(); i++) begin
      checks++;
      if (q_inst[i] !== insts[i]) begin
        errors++;
        $display("FAIL %s inst[%0d] got %h exp %h", name, i, q_inst[i], insts[i]);
      end
      if (mode != 2) begin
        checks++;
        if (q_inst_c[i] != start_c + 2 + i) begin
          errors++;
          $display("FAIL %s inst_cyc[%0d] got %0d exp %0d", name, i, q_inst_c[i],
                   start_c + 2 + i);
        end
      end
    end
    if (mode != 2) begin
      checks++;
      if (n_irdy != exp_n) begin
        errors++;
        $display("FAIL %s inst_ready_cycles got %0d exp %0d", name, n_irdy, exp_n);
      end
      checks++;
      if (n_drdy != (mode == 1 ? 2 * BL : BL)) begin
        errors++;
        $display("FAIL %s fill_cycles got %0d exp %0d", name, n_drdy,
                 (mode == 1 ? 2 * BL : BL));
      end
    end
    checks++;
    if (q_din.size() != BL) begin
      errors++;
      $display("FAIL %s din_count got %0d exp %0d", name, q_din.size(), BL);
    end
    for (int i = 0; i < BL && i < q_din.size(); i++) begin
      checks++;
      if (q_din[i] !== datas[i] || q_din_c[i] != q_din_c[0] + i) begin
        errors++;
        $display("FAIL %s din[%0d] got %h@%0d exp %h@%0d", name, i, q_din[i], q_din_c[i],
                 datas[i], q_din_c[0] + i);
      end
    end
    if (mode == 0 && q_din.size() > 0) begin
      checks++;
      if (q_din_c[0] != start_c + 1 + exp_n + BL + 1) begin
        errors++;
        $display("FAIL %s latency got %0d exp %0d", name, q_din_c[0] - start_c,
                 1 + exp_n + BL + 1);
      end
    end
    checks++;
    if (q_done_c.size() != 1) begin
      errors++;
      $display("FAIL %s done_pulses got %0d exp 1", name, q_done_c.size());
    end else if (q_din.size() > 0) begin
      checks++;
      if (q_done_c[0] != q_din_c[q_din_c.size()-1] + 1) begin
        errors++;
        $display("FAIL %s done_cyc got %0d exp %0d", name, q_done_c[0],
                 q_din_c[q_din_c.size()-1] + 1);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_job got %b exp 0", name, busy);
    end
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    #2;
    outs = {s_inst_ready, s_data_ready, inst_in_v, |inst_in, din_v, |din_pe, busy, done};
    checks++;
    if (outs !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000000", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] outs;
    int dp, budget;
    @(negedge clk);
    start = 1'b1; inst_cnt = 5'd0;
    @(negedge clk);
    start = 1'b0;
    dp = 0; budget = 200;
    while (dp < 20 && budget > 0) begin
      budget--;
      s_data_v = 1'b1;
      s_data = {$urandom(), $urandom()};
      if (s_data_ready) dp++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    outs = {s_inst_ready, s_data_ready, inst_in_v, |inst_in, din_v, |din_pe, busy, done};
    checks++;
    if (outs !== 8'h00 || dp != 20) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b words %0d exp 00000000 words 20", outs, dp);
    end
    s_data_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_job("after_reset", 0, 0, -1, 100, 1'b0);
  endtask

  initial begin
    test_reset();
    run_job("inst_abc", 3, 0, 'hA, 0, 1'b0);
    run_job("no_inst", 0, 0, -1, -1, 1'b0);
    run_job("toggle_fill", 5, 1, -1, -1, 1'b0);
    run_job("clamp", 20, 0, -1, -1, 1'b0);
    for (int r = 0; r < 3; r++)
      run_job("random_gaps", int'($urandom_range(1, 16)), 2, -1, -1, 1'b0);
    test_reset_mid();
    run_job("start_in_burst", 2, 0, -1, -1, 1'b1);
    run_job("max_inst", 16, 0, -1, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
